pe_seq: RTL and testbench

Job sequencer for a single 3x3 processing element (PE). It latches a job configuration, serially loads the nine 8-bit kernel weights, streams `len` nine-byte input windows into the PE, counts PE results, and signals completion. It sits between the accelerator's weight/activation buffers and one PE instance. PE latency is not hard-coded; completion is tracked from the PE's `out_en`.

---
 rtl/pe_seq_if.sv | 35 +++
 rtl/pe_seq.sv | 215 +++++++++++++++++++++
 tb/tb_pe_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_if.sv
// Stream and PE-drive bundle of the 3x3 PE job sequencer.
// The sequencer uses the master view. The environment (buffers and PE) uses the slave view.
interface pe_seq_if #(
    parameter int DW = 8,
    parameter int NK = 9
);
    logic              w_valid;
    logic [DW-1:0]     w_data;
    logic              w_ready;
    logic              x_valid;
    logic [DW*NK-1:0]  x_data;
    logic              x_ready;
    logic [DW*NK-1:0]  pe_in;
    logic [DW*NK-1:0]  pe_weight;
    logic [15:0]       pe_bias;
    logic [1:0]        pe_bound;
    logic [2:0]        pe_step;
    logic              pe_en;
    logic [DW-1:0]     pe_out;
    logic              pe_out_en;
    logic              y_valid;
    logic [DW-1:0]     y_data;

    modport master (
        input  w_valid, w_data, x_valid, x_data, pe_out, pe_out_en,
        output w_ready, x_ready, pe_in, pe_weight, pe_bias, pe_bound, pe_step, pe_en,
               y_valid, y_data
    );

    modport slave (
        output w_valid, w_data, x_valid, x_data, pe_out, pe_out_en,
        input  w_ready, x_ready, pe_in, pe_weight, pe_bias, pe_bound, pe_step, pe_en,
               y_valid, y_data
    );
endinterface

// File: rtl/pe_seq.sv
// Job sequencer for one 3x3 processing element: latches the job configuration,
// loads nine kernel weights, streams len windows into the PE, and counts PE
// results. A drain watchdog stops a job whose PE stops answering.
module pe_seq #(
    parameter int DW   = 8,
    parameter int NK   = 9,
    parameter int CW   = 16,
    parameter int WDOG = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cfg_len,
    input  logic [15:0]   cfg_bias,
    input  logic [1:0]    cfg_bound,
    input  logic [2:0]    cfg_step,
    pe_seq_if.master      bus,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int WCW = $clog2(NK);
    localparam int WDW = $clog2(WDOG + 1);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(NK - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(WDOG - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADW = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CW-1:0]      len_r, len_nxt_s;
    logic [CW-1:0]      in_cnt_r, in_cnt_nxt_s;
    logic [CW-1:0]      out_cnt_r, out_cnt_nxt_s;
    logic [WCW-1:0]     wcnt_r, wcnt_nxt_s;
    logic [WDW-1:0]     wd_r, wd_nxt_s;
    logic [DW*NK-1:0]   weight_r, weight_nxt_s;
    logic [DW*NK-1:0]   pe_in_r, pe_in_nxt_s;
    logic               pe_en_r, pe_en_nxt_s;
    logic [15:0]        bias_r, bias_nxt_s;
    logic [1:0]         bound_r, bound_nxt_s;
    logic [2:0]         step_r, step_nxt_s;
    logic               y_valid_r, y_valid_nxt_s;
    logic [DW-1:0]      y_data_r, y_data_nxt_s;
    logic               err_r, err_nxt_s;
    logic               busy_r, done_r, w_ready_r, x_ready_r;
    logic               w_hs_s, x_hs_s, last_in_s, last_out_s, wd_exp_s;

    assign bus.w_ready   = w_ready_r;
    assign bus.x_ready   = x_ready_r;
    assign bus.pe_in     = pe_in_r;
    assign bus.pe_weight = weight_r;
    assign bus.pe_bias   = bias_r;
    assign bus.pe_bound  = bound_r;
    assign bus.pe_step   = step_r;
    assign bus.pe_en     = pe_en_r;
    assign bus.y_valid   = y_valid_r;
    assign bus.y_data    = y_data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

    // Next-state and next-register values for the whole job flow.
    always_comb begin
        state_nxt_s   = state_r;
        len_nxt_s     = len_r;
        in_cnt_nxt_s  = in_cnt_r;
        out_cnt_nxt_s = out_cnt_r;
        wcnt_nxt_s    = wcnt_r;
        wd_nxt_s      = wd_r;
        weight_nxt_s  = weight_r;
        pe_in_nxt_s   = pe_in_r;
        pe_en_nxt_s   = 1'b0;
        bias_nxt_s    = bias_r;
        bound_nxt_s   = bound_r;
        step_nxt_s    = step_r;
        y_valid_nxt_s = 1'b0;
        y_data_nxt_s  = y_data_r;
        err_nxt_s     = err_r;
        w_hs_s        = bus.w_valid && w_ready_r;
        x_hs_s        = bus.x_valid && x_ready_r;
        last_in_s     = x_hs_s && ((in_cnt_r + CW'(1)) == len_r);
        last_out_s    = bus.pe_out_en && ((out_cnt_r + CW'(1)) == len_r);
        wd_exp_s      = (state_r == DRAIN) && !bus.pe_out_en && (wd_r == WD_LAST);

        case (state_r)
            IDLE: begin
                if (start) begin
                    err_nxt_s = 1'b0;
                    if (cfg_len != '0) begin
                        len_nxt_s     = cfg_len;
                        bias_nxt_s    = cfg_bias;
                        bound_nxt_s   = cfg_bound;
                        step_nxt_s    = cfg_step;
                        in_cnt_nxt_s  = '0;
                        out_cnt_nxt_s = '0;
                        wcnt_nxt_s    = '0;
                        wd_nxt_s      = '0;
                        state_nxt_s   = LOADW;
                    end else begin
                        // An empty job completes without touching the PE configuration.
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOADW: begin
                if (w_hs_s) begin
                    // weight[0] sits in the most significant byte lane.
                    for (int i = 0; i < NK; i++) begin
                        if (wcnt_r == WCW'(i)) begin
                            weight_nxt_s[DW*(NK-i)-1 -: DW] = bus.w_data;
                        end else begin
                            weight_nxt_s[DW*(NK-i)-1 -: DW] = weight_r[DW*(NK-i)-1 -: DW];
                        end
                    end
                    wcnt_nxt_s = wcnt_r + WCW'(1);
                    if (wcnt_r == WCNT_LAST) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = LOADW;
                    end
                end else begin
                    state_nxt_s = LOADW;
                end
            end
            RUN, DRAIN: begin
                if (x_hs_s) begin
                    pe_in_nxt_s  = bus.x_data;
                    pe_en_nxt_s  = 1'b1;
                    in_cnt_nxt_s = in_cnt_r + CW'(1);
                end else begin
                    pe_en_nxt_s = 1'b0;
                end
                if (bus.pe_out_en) begin
                    out_cnt_nxt_s = out_cnt_r + CW'(1);
                    y_valid_nxt_s = 1'b1;
                    y_data_nxt_s  = bus.pe_out;
                    wd_nxt_s      = '0;
                end else if (state_r == DRAIN) begin
                    wd_nxt_s = wd_r + WDW'(1);
                end else begin
                    wd_nxt_s = '0;
                end
                // Completion outranks the watchdog and the RUN-to-DRAIN step.
                if (last_out_s) begin
                    state_nxt_s = DONE;
                end else if (wd_exp_s) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = DONE;
                end else if ((state_r == RUN) && last_in_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters, PE drive and status registers; status outputs decode the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            len_r     <= '0;
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
            wcnt_r    <= '0;
            wd_r      <= '0;
            weight_r  <= '0;
            pe_in_r   <= '0;
            pe_en_r   <= 1'b0;
            bias_r    <= '0;
            bound_r   <= '0;
            step_r    <= '0;
            y_valid_r <= 1'b0;
            y_data_r  <= '0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_ready_r <= 1'b0;
            x_ready_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            in_cnt_r  <= in_cnt_nxt_s;
            out_cnt_r <= out_cnt_nxt_s;
            wcnt_r    <= wcnt_nxt_s;
            wd_r      <= wd_nxt_s;
            weight_r  <= weight_nxt_s;
            pe_in_r   <= pe_in_nxt_s;
            pe_en_r   <= pe_en_nxt_s;
            bias_r    <= bias_nxt_s;
            bound_r   <= bound_nxt_s;
            step_r    <= step_nxt_s;
            y_valid_r <= y_valid_nxt_s;
            y_data_r  <= y_data_nxt_s;
            err_r     <= err_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == DONE);
            w_ready_r <= (state_nxt_s == LOADW);
            x_ready_r <= (state_nxt_s == RUN);
        end
    end
endmodule

// File: tb/tb_pe_seq.sv
// Directed bench for pe_seq with a latency-2 PE model that returns pe_in[7:0]^0xA5.
module tb_pe_seq;
    localparam int DW = 8, NK = 9, CW = 16, WDOG = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start;
    logic [CW-1:0] cfg_len;
    logic [15:0]   cfg_bias;
    logic [1:0]    cfg_bound;
    logic [2:0]    cfg_step;
    logic          busy, done, err;

    pe_seq_if #(.DW(DW), .NK(NK)) bus ();

    pe_seq #(.DW(DW), .NK(NK), .CW(CW), .WDOG(WDOG)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_bias(cfg_bias), .cfg_bound(cfg_bound), .cfg_step(cfg_step),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // PE model: result two cycles after pe_en, suppressed once pe_limit results are made.
    logic       s1_en = 1'b0;
    logic [7:0] s1_d = 8'h00;
    int         pe_made = 0;
    int         pe_limit;
    always @(posedge clk) begin
        s1_en <= bus.pe_en;
        s1_d  <= bus.pe_in[7:0] ^ 8'hA5;
        if (s1_en && (pe_made < pe_limit)) begin
            bus.pe_out_en <= 1'b1;
            bus.pe_out    <= s1_d;
            pe_made       <= pe_made + 1;
        end else begin
            bus.pe_out_en <= 1'b0;
        end
    end

    // Monitor: samples just after the falling edge; collects results and timing violations.
    logic [7:0] yq[$];
    int  done_cnt = 0, done_cyc = 0, last_oe_cyc = 0, lag_bad = 0;
    int  run_len = 0, max_run = 0;
    logic prev_oe = 1'b0, prev_xhs = 1'b0;
    logic [7:0] prev_out = 8'h00;
    logic [DW*NK-1:0] prev_xd = '0;
    always @(negedge clk) begin
        #1;
        if (bus.y_valid) begin
            yq.push_back(bus.y_data);
            if (!prev_oe || bus.y_data !== prev_out) lag_bad++;
        end
        if (bus.pe_en) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (!prev_xhs || bus.pe_in !== prev_xd) lag_bad++;
        end else begin
            run_len = 0;
            if (prev_xhs) lag_bad++;
        end
        if (bus.pe_out_en === 1'b1) last_oe_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_oe  = (bus.pe_out_en === 1'b1);
        prev_out = bus.pe_out;
        prev_xhs = bus.x_valid && bus.x_ready;
        prev_xd  = bus.x_data;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 128'(done_cnt != base), 128'd1);
        @(negedge clk);
    endtask

    task automatic start_job(input logic [CW-1:0] len, input logic [15:0] bias,
                             input logic [1:0] bound, input logic [2:0] step);
        @(negedge clk);
        start = 1'b1; cfg_len = len; cfg_bias = bias; cfg_bound = bound; cfg_step = step;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_b2b(input logic [7:0] first);
        for (int i = 0; i < NK; i++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = first + 8'(i);
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
    endtask

    int dbase, ybase, gaps[5], scyc;

    initial begin
        start = 1'b0; cfg_len = '0; cfg_bias = '0; cfg_bound = '0; cfg_step = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.x_valid = 1'b0; bus.x_data = '0;
        pe_limit = 1 << 30;
        gaps = '{0, 1, 3, 2, 0};

        // Reset state
        #12 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_status", {busy, done, err}, 3'b000);
        chk("rst_ready", {bus.w_ready, bus.x_ready}, 2'b00);
        chk("rst_pe_cfg", {bus.pe_en, bus.pe_bias, bus.pe_bound, bus.pe_step}, 22'd0);
        chk("rst_weight", bus.pe_weight, 72'd0);
        chk("rst_pe_in", bus.pe_in, 72'd0);
        chk("rst_y", {bus.y_valid, bus.y_data}, 9'd0);

        // Job A: throttled weight load, then 64 back-to-back windows
        dbase = done_cnt; ybase = yq.size();
        start_job(16'd64, 16'h1234, 2'd2, 3'd5);
        chk("loadw_ready", {busy, bus.w_ready, bus.x_ready}, 3'b110);
        chk("cfg_latched", {bus.pe_bias, bus.pe_bound, bus.pe_step}, {16'h1234, 2'd2, 3'd5});
        for (int i = 0; i < NK; i++) begin
            bus.w_valid = 1'b1; bus.w_data = 8'(i + 1);
            @(negedge clk);
            bus.w_valid = 1'b0;
            chk("w_ready_after_hs", bus.w_ready, (i < NK - 1) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        chk("weight_a", bus.pe_weight, 72'h01_0203_0405_0607_0809);
        chk("run_ready", bus.x_ready, 1'b1);
        bus.w_valid = 1'b1; bus.w_data = 8'hFF;
        for (int j = 0; j < 64; j++) begin
            bus.x_valid = 1'b1;
            bus.x_data  = {NK{8'(j)}};
            start = (j == 20);
            cfg_bias = (j == 20) ? 16'hBEEF : 16'h1234;
            @(negedge clk);
        end
        bus.x_valid = 1'b0; start = 1'b0;
        wait_done(dbase, 60);
        bus.w_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_pe_en_run", max_run, 64);
        chk("a_y_count", yq.size() - ybase, 64);
        for (int j = 0; j < 64; j++) begin
            if (ybase + j < yq.size()) chk("a_y_data", yq[ybase + j], 8'(j) ^ 8'hA5);
        end
        chk("a_done_once", done_cnt - dbase, 1);
        chk("a_status", {busy, err}, 2'b00);
        chk("a_weight_hold", bus.pe_weight, 72'h01_0203_0405_0607_0809);
        chk("a_start_ignored", bus.pe_bias, 16'h1234);

        // Job B: len 5 with input gaps of 0-3 cycles
        dbase = done_cnt; ybase = yq.size();
        start_job(16'd5, 16'h0F0F, 2'd1, 3'd3);
        load_b2b(8'h11);
        for (int k = 0; k < 5; k++) begin
            bus.x_valid = 1'b1; bus.x_data = {NK{8'h40 + 8'(k)}};
            @(negedge clk);
            bus.x_valid = 1'b0;
            repeat (gaps[k]) @(negedge clk);
        end
        wait_done(dbase, 40);
        @(negedge clk);
        chk("b_weight", bus.pe_weight, 72'h11_1213_1415_1617_1819);
        chk("b_y_count", yq.size() - ybase, 5);
        for (int k = 0; k < 5; k++) begin
            if (ybase + k < yq.size()) chk("b_y_data", yq[ybase + k], (8'h40 + 8'(k)) ^ 8'hA5);
        end
        chk("b_done_once", done_cnt - dbase, 1);
        chk("b_err", err, 1'b0);

        // Job C: PE answers 3 of 4 windows, watchdog ends the job
        dbase = done_cnt; ybase = yq.size();
        pe_limit = pe_made + 3;
        start_job(16'd4, 16'h2222, 2'd3, 3'd7);
        load_b2b(8'h21);
        for (int k = 0; k < 4; k++) begin
            bus.x_valid = 1'b1; bus.x_data = {NK{8'h60 + 8'(k)}};
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
        wait_done(dbase, 80);
        chk("c_err", err, 1'b1);
        chk("c_done_once", done_cnt - dbase, 1);
        chk("c_y_count", yq.size() - ybase, 3);
        chk("c_wd_delay", 128'(done_cyc - last_oe_cyc), 128'd16);
        repeat (3) @(negedge clk);
        chk("c_err_hold", {busy, err}, 2'b01);
        pe_limit = 1 << 30;

        // Job D: cfg_len = 0 completes in one cycle, loads nothing, clears err
        @(negedge clk);
        start = 1'b1; cfg_len = 16'd0; cfg_bias = 16'hDEAD;
        scyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("d_done", {done, busy, bus.w_ready, err}, 4'b1100);
        chk("d_no_load", bus.pe_bias, 16'h2222);
        @(negedge clk);
        chk("d_done_pulse", {done, busy}, 2'b00);
        chk("d_done_lat", 128'(done_cyc - scyc), 128'd1);

        // Job F: best-case latency, len 1, window waiting before RUN
        dbase = done_cnt; ybase = yq.size();
        @(negedge clk);
        start = 1'b1; cfg_len = 16'd1; cfg_bias = 16'h0001;
        scyc = cyc;
        @(negedge clk);
        start = 1'b0;
        bus.x_valid = 1'b1; bus.x_data = {NK{8'h7E}};
        load_b2b(8'h31);
        @(negedge clk);
        bus.x_valid = 1'b0;
        wait_done(dbase, 30);
        chk("f_latency", 128'(done_cyc - scyc), 128'd14);
        chk("f_y_count", yq.size() - ybase, 1);
        if (ybase < yq.size()) chk("f_y_data", yq[ybase], 8'h7E ^ 8'hA5);

        // Job E: reset low in the middle of RUN
        start_job(16'd10, 16'h3333, 2'd1, 3'd1);
        load_b2b(8'h41);
        for (int k = 0; k < 3; k++) begin
            bus.x_valid = 1'b1; bus.x_data = {NK{8'h50 + 8'(k)}};
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        dbase = done_cnt; ybase = yq.size();
        chk("e_rst_status", {busy, done, err, bus.w_ready, bus.x_ready, bus.pe_en, bus.y_valid}, 7'd0);
        chk("e_rst_regs", {bus.pe_weight, bus.pe_in, bus.pe_bias}, 160'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("e_no_done", done_cnt - dbase, 0);
        chk("e_no_y", yq.size() - ybase, 0);
        chk("e_idle", busy, 1'b0);
        chk("timing_lags", lag_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
